// File: rtl/branch_resolve_unit_if.sv
// Branch issue/resolve bus between ID/EX and the resolve unit, plus predictor-update and flush returns.
// master = pipeline side driving issue/resolve; slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int AW = 32
);
    logic          issue_i;
    logic          issue_pred_i;
    logic [AW-1:0] issue_pc_i;
    logic [AW-1:0] issue_target_i;
    logic          resolve_i;
    logic          resolve_taken_i;
    logic          stall_o;
    logic          update_o;
    logic          result_o;
    logic          flush_o;
    logic [AW-1:0] redirect_pc_o;
    logic          err_o;

    modport master (
        output issue_i, issue_pred_i, issue_pc_i, issue_target_i, resolve_i, resolve_taken_i,
        input  stall_o, update_o, result_o, flush_o, redirect_pc_o, err_o
    );

    modport slave (
        input  issue_i, issue_pred_i, issue_pc_i, issue_target_i, resolve_i, resolve_taken_i,
        output stall_o, update_o, result_o, flush_o, redirect_pc_o, err_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose: in-order queue of predicted branches; compares prediction with EX outcome, updates predictor, flushes on miss.
// Latency: update/result/flush/redirect registered, one cycle after resolve_i. Optional BRU_STATS_EN adds counters.
// Backpressure: stall_o (combinational from count) when DEPTH branches outstanding; an issue while full is dropped and flags err_o.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
    ,
    output logic [15:0]           branch_cnt_o,
    output logic [15:0]           mispred_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic          pred;
        logic [AW-1:0] pc;
        logic [AW-1:0] target;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          update_q, update_d;
    logic          result_q, result_d;
    logic          flush_q, flush_d;
    logic          err_q, err_d;
    logic [AW-1:0] redirect_q, redirect_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          mispred;
    entry_t        head;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        head    = mem_q[rd_ptr_q];
        pop     = bus.resolve_i && !empty;
        mispred = pop && (head.pred != bus.resolve_taken_i);
        // An issue alongside a mispredicting resolve is younger than the branch and gets squashed.
        push    = bus.issue_i && !full && !mispred;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        update_d   = pop;
        result_d   = pop && bus.resolve_taken_i;
        flush_d    = mispred;
        redirect_d = redirect_q;
        err_d      = err_q
                   | (bus.issue_i && full && !mispred)
                   | (bus.resolve_i && empty);

        if (pop) begin
            redirect_d = bus.resolve_taken_i ? head.target : head.pc + AW'(4);
        end

        if (mispred) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            update_q   <= 1'b0;
            result_q   <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            redirect_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            update_q   <= update_d;
            result_q   <= result_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
            redirect_q <= redirect_d;
        end
    end

    // Payload storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pred:   bus.issue_pred_i,
                                 pc:     bus.issue_pc_i,
                                 target: bus.issue_target_i};
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop && (branch_cnt_q != 16'hFFFF))      branch_cnt_d  = branch_cnt_q + 16'd1;
        if (mispred && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif

    assign bus.stall_o       = full;
    assign bus.update_o      = update_q;
    assign bus.result_o      = result_q;
    assign bus.flush_o       = flush_q;
    assign bus.redirect_pc_o = redirect_q;
    assign bus.err_o         = err_q;
endmodule
